// File: rtl/ram_ctrl.sv
// Valid/ready initiator for a 1024x8 single-port synchronous RAM with a shared data bus.
// Optional macro RAM_CTRL_TURNAROUND_EN inserts one idle bus cycle after every read.
module ram_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              mem_cs,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        RD_REQ = 3'd2,
        RD_CAP = 3'd3
`ifdef RAM_CTRL_TURNAROUND_EN
        ,
        TURN   = 3'd4
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept;

    logic                r_ready;
    logic                r_busy;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_mem_cs;
    logic                r_mem_rd;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_wdata;

    assign w_accept = req_valid && r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = req_we ? WR : RD_REQ;
                end
            end
            WR:     w_state_next = IDLE;
            RD_REQ: w_state_next = RD_CAP;
`ifdef RAM_CTRL_TURNAROUND_EN
            RD_CAP: w_state_next = TURN;
            TURN:   w_state_next = IDLE;
`else
            RD_CAP: w_state_next = IDLE;
`endif
            default: w_state_next = IDLE;
        endcase
    end

    // Pin and handshake registers are loaded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_cs    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_wdata     <= '0;
        end else begin
            r_ready     <= (w_state_next == IDLE);
            r_busy      <= (w_state_next != IDLE);
            r_mem_cs    <= (w_state_next == WR) || (w_state_next == RD_REQ) ||
                           (w_state_next == RD_CAP);
            r_mem_rd    <= (w_state_next == RD_REQ) || (w_state_next == RD_CAP);
            r_mem_wr    <= (w_state_next == WR);
            r_rsp_valid <= (r_state == WR) || (r_state == RD_CAP);
            if (w_accept) begin
                r_mem_addr <= req_addr;
                r_wdata    <= req_wdata;
            end
            if (r_state == RD_CAP) begin
                r_rsp_rdata <= mem_data;
            end
        end
    end

    // The write strobe doubles as the bus drive enable.
    assign mem_data  = r_mem_wr ? r_wdata : {DATA_W{1'bz}};

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_cs    = r_mem_cs;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: behavioural 1024x8 RAM, request scoreboard, bus checker.
module tb_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [9:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       mem_cs;
    logic       mem_rd;
    logic       mem_wr;
    logic [9:0] mem_addr;
    wire  [7:0] mem_data;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_ctrl #(.ADDR_W(10), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_data(mem_data)
    );

    // RAM model: writes at the edge, read data registered then driven the following cycle.
    logic [7:0] ram [1024];
    logic [7:0] ram_q = '0;
    logic       ram_oe = 1'b0;
    logic       ram_drv;
    assign ram_drv  = ram_oe && mem_cs && mem_rd;
    assign mem_data = ram_drv ? ram_q : 8'bz;
    always @(posedge clk) begin
        if (mem_cs && mem_wr) ram[mem_addr] <= mem_data;
        if (mem_cs && mem_rd) ram_q <= ram[mem_addr];
        ram_oe <= mem_cs && mem_rd;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    typedef struct {
        logic       is_rd;
        logic [7:0] data;
        int         due;
    } sb_t;
    sb_t sbq[$];

    always @(negedge clk) begin
        sb_t e;
        if (rst_n && rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(e.due));
                chk(e.is_rd ? "rsp_rdata_read" : "rsp_rdata_hold", 32'(rsp_rdata), 32'(e.data));
            end
        end
        if (rst_n) begin
            chk("bus_rd_wr_excl", 32'(mem_rd && mem_wr), 32'd0);
            if (ram_drv) chk("bus_rdcap_x", 32'($isunknown(mem_data)), 32'd0);
        end
    end

    task automatic issue(input logic we, input logic [9:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, output int acc);
        sb_t e;
        int  n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        e.is_rd = !we; e.data = exp_rd; e.due = cyc + (we ? 2 : 3);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the controller must ignore them.
        req_valid = 1'b0; req_we = 1'($urandom);
        req_addr = 10'($urandom); req_wdata = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sbq.size()), 32'd0);
    endtask

    typedef struct {
        logic       we;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int acc, acc_r, acc_w;
        logic [7:0] last_rd;

        tbl[0] = '{1'b1, 10'h3A5, 8'hC3, 8'h00};
        tbl[1] = '{1'b0, 10'h3A5, 8'h00, 8'hC3};
        tbl[2] = '{1'b1, 10'h000, 8'h11, 8'hC3};
        tbl[3] = '{1'b1, 10'h3FF, 8'hEE, 8'hC3};
        tbl[4] = '{1'b0, 10'h000, 8'h00, 8'h11};
        tbl[5] = '{1'b0, 10'h3FF, 8'h00, 8'hEE};
        tbl[6] = '{1'b1, 10'h3A5, 8'h00, 8'hEE};
        tbl[7] = '{1'b0, 10'h3A5, 8'hFF, 8'h00};

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_pins", 32'({mem_cs, mem_rd, mem_wr}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, acc);
            if (tbl[i].we) chk("tbl_wr_drive", 32'({mem_wr, mem_data}), 32'({1'b1, tbl[i].wdata}));
            else chk("tbl_rd_pins", 32'({mem_cs, mem_rd, mem_wr, mem_addr}),
                     32'({3'b110, tbl[i].addr}));
        end
        drain();
        last_rd = 8'h00;

        for (int a = 0; a < 1024; a++)
            issue(1'b1, 10'(a), 8'(a) ^ 8'h5A, last_rd, acc);
        for (int a = 0; a < 1024; a++) begin
            issue(1'b0, 10'(a), 8'h00, 8'(a) ^ 8'h5A, acc);
            last_rd = 8'(a) ^ 8'h5A;
        end
        drain();

        // Asynchronous reset in the middle of RD_CAP.
        issue(1'b0, 10'h010, 8'h00, 8'h4A, acc);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_in_rdcap", 32'({mem_cs, mem_rd}), 32'b11);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_pins", 32'({mem_cs, mem_rd, mem_wr}), 32'd0);
        chk("midrst_busy_ready", 32'({busy, req_ready, rsp_valid}), 32'd0);
        chk("midrst_addr_rdata", 32'({mem_addr, rsp_rdata}), 32'd0);
        sbq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rel_ready", 32'(req_ready), 32'd1);
        issue(1'b0, 10'h010, 8'h00, 8'h4A, acc);
        drain();

        // Cycle-by-cycle view of the read tail.
        issue(1'b0, 10'h3FF, 8'h00, 8'hA5, acc);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("c3_mem_cs", 32'(mem_cs), 32'd0);
        chk("c3_rsp_valid", 32'(rsp_valid), 32'd1);
`ifdef RAM_CTRL_TURNAROUND_EN
        chk("c3_ready_turn", 32'({req_ready, busy}), 32'b01);
        @(negedge clk);
        chk("c4_ready_turn", 32'({req_ready, busy}), 32'b10);
`else
        chk("c3_ready", 32'({req_ready, busy}), 32'b10);
`endif
        drain();

        // Read followed immediately by a write.
        issue(1'b0, 10'h020, 8'h00, 8'h7A, acc_r);
        issue(1'b1, 10'h020, 8'h77, 8'h7A, acc_w);
`ifdef RAM_CTRL_TURNAROUND_EN
        chk("rd_wr_gap", 32'(acc_w - acc_r), 32'd4);
`else
        chk("rd_wr_gap", 32'(acc_w - acc_r), 32'd3);
`endif
        chk("rd_wr_drive", 32'({mem_cs, mem_wr, mem_rd, mem_data}), 32'({3'b110, 8'h77}));
        issue(1'b0, 10'h020, 8'h00, 8'h77, acc);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Bus-side initiator for the single-port 1024x8 synchronous RAM with the shared bidirectional data bus. It accepts read/write requests on a valid/ready handshake and sequences the RAM's cs/rd/wr/addr/data pins with the correct cycle timing. It captures read data off the shared bus and returns it on a response strobe. It sits between any internal requester (FSM, DMA, test driver) and the RAM instance.

## Interface
- ADDR_W, 10, RAM address width (1024 locations)
- DATA_W, 8, RAM data width
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept; high only in IDLE
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  request address
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  one-cycle pulse: request completed (read or write)
- rsp_rdata  output  DATA_W  read data; valid with rsp_valid of a read, holds until next read completes
- busy  output  1  high in any state other than IDLE
- mem_cs  output  1  RAM chip select
- mem_rd  output  1  RAM read strobe
- mem_wr  output  1  RAM write strobe
- mem_addr  output  ADDR_W  RAM address
- mem_data  inout  DATA_W  shared RAM data bus; driven by ram_ctrl only while mem_wr is high, else high-Z

## Operation
- States: IDLE, WR, RD_REQ, RD_CAP, TURN (TURN only with the macro).
- Accept: req_valid && req_ready at a rising edge. req_we/addr/wdata are registered at accept; later changes are ignored.
- IDLE -> WR (req_we=1) or RD_REQ (req_we=0) on accept; otherwise stay.
- WR: mem_cs=1, mem_wr=1, mem_rd=0, mem_addr=latched addr, mem_data driven with latched wdata. RAM writes at the closing edge. -> IDLE, rsp_valid=1 next cycle.
- RD_REQ: mem_cs=1, mem_rd=1, mem_wr=0, mem_addr held. RAM latches its output register at the closing edge. -> RD_CAP.
- RD_CAP: same pin values as RD_REQ; RAM drives mem_data. ram_ctrl samples mem_data into rsp_rdata at the closing edge. -> IDLE (or TURN), rsp_valid=1 next cycle.
- All mem_* outputs and the mem_data drive enable are registered. They are never both mem_rd and mem_wr high. mem_cs=0 and rd=wr=0 in IDLE/TURN. mem_addr holds its last value when idle.
- Addresses are used as given. 1023 and 0 need no special handling and there is no wrap logic.
- Asynchronous reset mid-operation: state goes to IDLE and all outputs drop at once. The bus is released and the in-flight request is discarded with no rsp_valid.

## Timing
- Reset values: req_ready=0 while rst_n low; rsp_valid=0, rsp_rdata=0, busy=0, mem_cs=mem_rd=mem_wr=0, mem_addr=0, mem_data high-Z.
- Accept in cycle C0. Write: bus cycle C1; rsp_valid and req_ready in C2. Write-to-write throughput is 1 per 2 cycles.
- Read: RD_REQ in C1, RD_CAP in C2; rsp_valid with rsp_rdata in C3. Without the macro, req_ready is in C3 (1 per 3 cycles).
- rsp_valid is exactly one cycle wide and has no backpressure; the requester must sample it.
- A new accept may occur in the same cycle rsp_valid is high.

## Configuration
- RAM_CTRL_TURNAROUND_EN defined: RD_CAP -> TURN -> IDLE. TURN lasts one cycle with mem_cs=0 and req_ready=0, guaranteeing one idle bus cycle before a following write drives mem_data. rsp_valid still occurs in C3 (the TURN cycle), and req_ready returns in C4.
- Undefined: RD_CAP -> IDLE directly, with no TURN state.

## Test plan
- Reset: hold rst_n low for 3 cycles mid-stream -> all outputs at reset values and mem_data high-Z. req_ready=1 in the first cycle after release.
- Write 0x3A5 <- 0xC3, then read 0x3A5 -> write rsp_valid 2 cycles after accept; read rsp_valid 3 cycles after accept with rsp_rdata=0xC3.
- Write all 1024 addresses back-to-back with data = addr[7:0]^0x5A, then read all back -> every rsp_rdata matches, including 0x000 and 0x3FF.
- Bus checker over all tests -> mem_rd&&mem_wr never true. mem_data is never X while mem_cs&&mem_rd in RD_CAP, and ram_ctrl drives only when mem_wr=1.
- Pull rst_n low during RD_CAP of a read of 0x010 -> mem_cs/rd drop the same cycle and no rsp_valid follows. A subsequent read of 0x010 returns the stored value.
- Read then immediate write, with macro -> exactly one cycle with mem_cs=0 and req_ready=0 between RD_CAP and WR. Without the macro -> WR can start in C4 after read accept in C0.
